wb_regfile: RTL and testbench

Write-back end of the operand path. Captures the MEM-stage result into a MEM/WB staging register and commits it to the 32x32 general-purpose register file. Serves the two ID-stage read ports that produce the operands later carried as reg0/reg1 through the ID/EX register. Also provides write-back-to-decode bypass and register-0 hardwiring.

---
 rtl/wb_regfile_pkg.sv | 21 ++
 rtl/wb_regfile_if.sv | 44 ++++
 rtl/wb_regfile_array.sv | 43 ++++
 rtl/wb_regfile.sv | 110 +++++++++++
 tb/tb_wb_regfile.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// openmips_defs
// Shared constants for the write-back / register-file slice of the operand
// path: default widths, the zero word, the hardwired-zero register address
// and the enable encodings used on the read and write controls.
// No ports (package).
// ---------------------------------------------------------------------------
package openmips_defs;

  localparam int DW_DEFAULT   = 32;  // data word width
  localparam int AW_DEFAULT   = 5;   // register address width
  localparam int NREG_DEFAULT = 32;  // architectural registers (2**AW)

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bundles the signals between the pipeline and the write-back register file.
//   stall, flush                  : staging-register control
//   mem_wd, mem_wreg, mem_wdata   : MEM-stage result entering write-back
//   re0/raddr0, re1/raddr1        : ID-stage read requests
//   rdata0, rdata1                : combinational read data
//   wb_wd, wb_wreg, wb_wdata      : registered write-back stage contents
// modport slave  : seen by the register file
// modport master : seen by the pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5
) ();

  logic          stall;
  logic          flush;
  logic [AW-1:0] mem_wd;
  logic          mem_wreg;
  logic [DW-1:0] mem_wdata;
  logic          re0;
  logic [AW-1:0] raddr0;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] wb_wd;
  logic          wb_wreg;
  logic [DW-1:0] wb_wdata;

  modport slave (
    input  stall, flush, mem_wd, mem_wreg, mem_wdata,
    input  re0, raddr0, re1, raddr1,
    output rdata0, rdata1, wb_wd, wb_wreg, wb_wdata
  );

  modport master (
    output stall, flush, mem_wd, mem_wreg, mem_wdata,
    output re0, raddr0, re1, raddr1,
    input  rdata0, rdata1, wb_wd, wb_wreg, wb_wdata
  );

endinterface

// File: rtl/wb_regfile_array.sv
// ---------------------------------------------------------------------------
// regfile_array
// NREG x DW storage. Every entry is cleared by the asynchronous reset so no
// read can ever return X. One synchronous write port, two raw combinational
// read ports (no zero-masking or bypass here; the top level owns that).
//   clk                 : clock, writes on rising edge
//   rst_                : asynchronous active-high clear of all entries
//   we_i/waddr_i/wdata_i: write port
//   raddr0_i/rdata0_o   : raw read port 0
//   raddr1_i/rdata1_o   : raw read port 1
// ---------------------------------------------------------------------------
module regfile_array #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back end of the operand path: MEM/WB staging register, commit into
// the general-purpose register file, and the two ID-stage read ports with
// register-0 hardwiring and write-back-to-decode bypass.
//   clk  : clock, all state on rising edge
//   rst_ : asynchronous active-high reset
//   bus  : wb_regfile_if.slave (staging control, MEM inputs, read ports,
//          registered wb_* outputs)
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DW   = openmips_defs::DW_DEFAULT,
  parameter int AW   = openmips_defs::AW_DEFAULT,
  parameter int NREG = openmips_defs::NREG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_,
  wb_regfile_if.slave  bus
);

  import openmips_defs::*;

  // ---------------- MEM/WB staging register ----------------
  logic [AW-1:0] wb_wd_q,    wb_wd_d;
  logic          wb_wreg_q,  wb_wreg_d;
  logic [DW-1:0] wb_wdata_q, wb_wdata_d;

  always_comb begin
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    if (bus.flush) begin
      // flush takes priority over stall: a squashed slot must never commit
      wb_wd_d    = NOP_REG_ADDR;
      wb_wreg_d  = WRITE_DISABLE;
      wb_wdata_d = ZERO_WORD;
    end else if (!bus.stall) begin
      wb_wd_d    = bus.mem_wd;
      wb_wreg_d  = bus.mem_wreg;
      wb_wdata_d = bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wb_wd_q    <= NOP_REG_ADDR;
      wb_wreg_q  <= WRITE_DISABLE;
      wb_wdata_q <= ZERO_WORD;
    end else begin
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign bus.wb_wd    = wb_wd_q;
  assign bus.wb_wreg  = wb_wreg_q;
  assign bus.wb_wdata = wb_wdata_q;

  // ---------------- commit ----------------
  // Commit uses the staged (pre-edge) values. A stalled entry is rewritten
  // every edge with the same data, which is harmless. Writes to r0 are
  // dropped here so the array entry 0 stays at its reset value.
  logic commit_we;
  assign commit_we = (wb_wreg_q == WRITE_ENABLE) && (wb_wd_q != NOP_REG_ADDR);

  logic [1:0][DW-1:0] raw_rdata;
  logic [1:0][AW-1:0] raddr;
  logic [1:0]         re;

  assign raddr = {bus.raddr1, bus.raddr0};
  assign re    = {bus.re1, bus.re0};

  regfile_array #(
    .DW   (DW),
    .AW   (AW),
    .NREG (NREG)
  ) u_array (
    .clk      (clk),
    .rst_     (rst_),
    .we_i     (commit_we),
    .waddr_i  (wb_wd_q),
    .wdata_i  (wb_wdata_q),
    .raddr0_i (raddr[0]),
    .raddr1_i (raddr[1]),
    .rdata0_o (raw_rdata[0]),
    .rdata1_o (raw_rdata[1])
  );

  // ---------------- read ports ----------------
  // The bypass covers the one-cycle window where a value sits in the
  // staging register but has not yet been committed to the array.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DW-1:0] rdata;
    always_comb begin
      rdata = raw_rdata[gi];
      if (re[gi] != READ_ENABLE) begin
        rdata = ZERO_WORD;
      end else if (raddr[gi] == NOP_REG_ADDR) begin
        rdata = ZERO_WORD;
      end else if ((wb_wreg_q == WRITE_ENABLE) && (wb_wd_q == raddr[gi])) begin
        rdata = wb_wdata_q;
      end
    end
  end

  assign bus.rdata0 = g_rd[0].rdata;
  assign bus.rdata1 = g_rd[1].rdata;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile: directed scenarios followed by a
// randomized stream, all compared against a behavioural model of the
// register file (register array + one staged write slot).
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst_ = 1'b1;

  always #5 clk = ~clk;

  wb_regfile_if #(.DW(32), .AW(5)) bus ();

  wb_regfile dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_data;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_wd   = 5'd0;
    m_wreg = 1'b0;
    m_data = 32'h0;
  endfunction

  // What a read of register a should return right now.
  function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
    if (!e || a == 5'd0) return 32'h0;
    if (m_wreg && m_wd == a) return m_data;
    return m_regs[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given MEM/control inputs; checks staged outputs.
  task automatic cyc(input logic st, input logic fl, input logic wr,
                     input logic [4:0] wd, input logic [31:0] wdat);
    bus.stall     = st;
    bus.flush     = fl;
    bus.mem_wreg  = wr;
    bus.mem_wd    = wd;
    bus.mem_wdata = wdat;
    @(posedge clk);
    if (m_wreg && m_wd != 5'd0) m_regs[m_wd] = m_data;
    if (fl) begin
      m_wd = 5'd0; m_wreg = 1'b0; m_data = 32'h0;
    end else if (!st) begin
      m_wd = wd; m_wreg = wr; m_data = wdat;
    end
    #1;
    check("wb_wreg",  {31'h0, bus.wb_wreg}, {31'h0, m_wreg});
    check("wb_wd",    {27'h0, bus.wb_wd},   {27'h0, m_wd});
    check("wb_wdata", bus.wb_wdata, m_data);
  endtask

  // Apply read requests and check both ports against the model.
  task automatic rd(input logic e0, input logic [4:0] a0,
                    input logic e1, input logic [4:0] a1);
    bus.re0 = e0; bus.raddr0 = a0;
    bus.re1 = e1; bus.raddr1 = a1;
    #1;
    check("rdata0", bus.rdata0, model_read(e0, a0));
    check("rdata1", bus.rdata1, model_read(e1, a1));
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0; bus.mem_wreg = 0; bus.mem_wd = 0;
    bus.mem_wdata = 0; bus.re0 = 0; bus.raddr0 = 0; bus.re1 = 0; bus.raddr1 = 0;
    model_reset();

    // 1. reset state
    #2;
    check("rst wb_wreg",  {31'h0, bus.wb_wreg}, 32'h0);
    check("rst wb_wdata", bus.wb_wdata, 32'h0);
    @(negedge clk);
    rst_ = 1'b0;
    rd(1, 5'd7, 1, 5'd7);
    check("rst r7", bus.rdata0, 32'h0);

    // 2. bypass then array
    cyc(0, 0, 1, 5'd3, 32'hDEADBEEF);
    rd(1, 5'd3, 0, 5'd0);
    check("bypass r3", bus.rdata0, 32'hDEADBEEF);
    cyc(0, 0, 0, 5'd0, 32'h0);
    rd(1, 5'd3, 1, 5'd3);
    check("array r3", bus.rdata0, 32'hDEADBEEF);

    // 3. register 0 hardwired
    rd(0, 5'd0, 1, 5'd0);
    cyc(0, 0, 1, 5'd0, 32'h12345678);
    rd(0, 5'd0, 1, 5'd0);
    check("r0 staged", bus.rdata1, 32'h0);
    cyc(0, 0, 0, 5'd0, 32'h0);
    rd(1, 5'd0, 1, 5'd0);
    check("r0 commit", bus.rdata1, 32'h0);

    // 4. stall / flush
    cyc(0, 0, 1, 5'd5, 32'hAAAA0001);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 5'd5, 32'hBBBB0002);
      check("stall hold", bus.wb_wdata, 32'hAAAA0001);
    end
    cyc(1, 1, 1, 5'd5, 32'hBBBB0002);
    check("flush wreg", {31'h0, bus.wb_wreg}, 32'h0);
    rd(1, 5'd5, 1, 5'd5);
    check("r5 after flush", bus.rdata0, 32'hAAAA0001);
    cyc(0, 0, 0, 5'd0, 32'h0);
    rd(1, 5'd5, 0, 5'd5);
    check("r5 settled", bus.rdata0, 32'hAAAA0001);

    // 5. dual read / read disable
    cyc(0, 0, 1, 5'd9, 32'h0F0F0F0F);
    cyc(0, 0, 0, 5'd0, 32'h0);
    cyc(0, 0, 0, 5'd0, 32'h0);
    rd(1, 5'd9, 0, 5'd9);
    check("dual r0", bus.rdata0, 32'h0F0F0F0F);
    check("dual r1 off", bus.rdata1, 32'h0);
    rd(1, 5'd9, 1, 5'd9);
    check("dual same", bus.rdata1, 32'h0F0F0F0F);

    // 6. back-to-back overwrite
    cyc(0, 0, 1, 5'd4, 32'h1);
    rd(1, 5'd4, 0, 5'd0);
    check("b2b first", bus.rdata0, 32'h1);
    cyc(0, 0, 1, 5'd4, 32'h2);
    rd(1, 5'd4, 0, 5'd0);
    check("b2b second", bus.rdata0, 32'h2);
    cyc(0, 0, 0, 5'd0, 32'h0);
    rd(1, 5'd4, 0, 5'd0);
    check("b2b array", bus.rdata0, 32'h2);

    // Asynchronous reset mid-stream, released between edges
    cyc(0, 0, 1, 5'd7, 32'hCAFEF00D);
    #1;
    rst_ = 1'b1;
    #1;
    model_reset();
    check("async wb_wreg", {31'h0, bus.wb_wreg}, 32'h0);
    rd(1, 5'd7, 1, 5'd4);
    check("async r4", bus.rdata1, 32'h0);
    rst_ = 1'b0;
    cyc(0, 0, 1, 5'd6, 32'h600D600D);
    check("post-rst capture", bus.wb_wdata, 32'h600D600D);

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a0, a1;
      cyc(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
          5'($urandom_range(31)), $urandom);
      a0 = ($urandom_range(2) == 0) ? bus.wb_wd : 5'($urandom_range(31));
      a1 = ($urandom_range(3) == 0) ? a0 : 5'($urandom_range(31));
      rd(($urandom_range(7) != 0), a0, ($urandom_range(7) != 0), a1);
    end

    // Sweep every register through port 1 once the stream has settled
    cyc(0, 0, 0, 5'd0, 32'h0);
    cyc(0, 0, 0, 5'd0, 32'h0);
    for (int r = 0; r < 32; r++) begin
      rd(0, 5'd0, 1, 5'(r));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
